// File: rtl/usr_seq_ctrl_if.sv
// Host request and USR control/status bundle for usr_seq_ctrl.
// prev is present only when USR_PREV_CAPTURE_EN is defined.
interface usr_seq_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             dir;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dout;
   logic [1:0]       sel;
   logic             rdin;
   logic             ldin;
   logic [WIDTH-1:0] pout_in;
   logic             rdout_in;
   logic             ldout_in;
`ifdef USR_PREV_CAPTURE_EN
   logic [WIDTH-1:0] prev;

   modport master (
      output start, dir, din, pout_in, rdout_in, ldout_in,
      input  busy, done, dout, sel, rdin, ldin, prev
   );
   modport slave (
      input  start, dir, din, pout_in, rdout_in, ldout_in,
      output busy, done, dout, sel, rdin, ldin, prev
   );
`else
   modport master (
      output start, dir, din, pout_in, rdout_in, ldout_in,
      input  busy, done, dout, sel, rdin, ldin
   );
   modport slave (
      input  start, dir, din, pout_in, rdout_in, ldout_in,
      output busy, done, dout, sel, rdin, ldin
   );
`endif
endinterface

// File: rtl/usr_seq_ctrl.sv
// Loads a word into a universal shift register serially, then reads it back in parallel.
// Optional USR_PREV_CAPTURE_EN adds prev: the USR contents displaced by the load.
module usr_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           rst,
   usr_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {IDLE, SHIFT, CAP1, CAP2, SAMP} state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic             dir_q;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] dout_q;
   logic [1:0]       sel_q;
   logic             rdin_q;
   logic             ldin_q;

   // Serial lines are registered one cycle ahead: each edge presents the bit the USR takes next.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sreg   <= '0;
         dir_q  <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dout_q <= '0;
         sel_q  <= 2'b00;
         rdin_q <= 1'b0;
         ldin_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sreg   <= bus.din;
                  dir_q  <= bus.dir;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= SHIFT;
                  sel_q  <= bus.dir ? 2'b10 : 2'b01;
                  rdin_q <= ~bus.dir & bus.din[0];
                  ldin_q <= bus.dir & bus.din[WIDTH-1];
               end
            end
            SHIFT: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state  <= CAP1;
                  sel_q  <= 2'b11;
                  rdin_q <= 1'b0;
                  ldin_q <= 1'b0;
               end else if (dir_q) begin
                  sreg   <= {sreg[WIDTH-2:0], 1'b0};
                  ldin_q <= sreg[WIDTH-2];
               end else begin
                  sreg   <= {1'b0, sreg[WIDTH-1:1]};
                  rdin_q <= sreg[1];
               end
            end
            CAP1: state <= CAP2;
            CAP2: begin
               state <= SAMP;
               sel_q <= 2'b00;
            end
            SAMP: begin
               dout_q <= bus.pout_in;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dout = dout_q;
   assign bus.sel  = sel_q;
   assign bus.rdin = rdin_q;
   assign bus.ldin = ldin_q;

`ifdef USR_PREV_CAPTURE_EN
   logic [WIDTH-1:0] prev_q;
   logic [CW-1:0]    k;
   logic [CW-1:0]    pidx;
   logic             serial_out;
   logic             prev_we;

   // k is the shift edge whose displaced bit is now on the serial output.
   always_comb begin
      k          = (state == CAP1) ? CW'(WIDTH) : cnt;
      pidx       = dir_q ? (CW'(WIDTH) - k) : (k - CW'(1));
      serial_out = dir_q ? bus.ldout_in : bus.rdout_in;
      prev_we    = ((state == SHIFT) && (cnt != '0)) || (state == CAP1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else if (prev_we) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (CW'(i) == pidx) prev_q[i] <= serial_out;
         end
      end
   end

   assign bus.prev = prev_q;
`endif
endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Scoreboard bench for usr_seq_ctrl with a behavioural USR attached to its control lines.
// Define USR_PREV_CAPTURE_EN to also check prev.
module tb_usr_seq_ctrl;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   usr_seq_ctrl_if #(.WIDTH(W)) bus ();
   usr_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural USR: serial-out registered, two-stage parallel capture.
   logic [W-1:0] uq = '0;
   logic [W-1:0] ucap = '0;
   logic [W-1:0] upout = '0;
   logic         urd = 1'b0;
   logic         uld = 1'b0;

   always @(posedge clk) begin
      case (bus.sel)
         2'b01: begin uq <= {bus.rdin, uq[W-1:1]}; urd <= uq[0]; end
         2'b10: begin uq <= {uq[W-2:0], bus.ldin}; uld <= uq[W-1]; end
         2'b11: begin ucap <= uq; upout <= ucap; end
         default: ;
      endcase
   end

   assign bus.pout_in  = upout;
   assign bus.rdout_in = urd;
   assign bus.ldout_in = uld;

   typedef struct {
      logic [W-1:0] dout;
      logic [W-1:0] prev;
      int           at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   edge_n = 0;
   int   m_left = 0;
   int   dones  = 0;

   // Reference acceptance: idle once W+3 edges have passed since the last accept.
   always @(posedge clk) begin
      edge_n <= edge_n + 1;
      if (rst) begin
         m_left <= 0;
         sb.delete();
      end else if (m_left == 0 && bus.start) begin
         sb.push_back('{dout: bus.din, prev: uq, at: edge_n + 1 + W + 3});
         m_left <= W + 3;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
      end
   end

   always @(negedge clk) begin
      if (bus.done) begin
         dones++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("done_edge", edge_n, e.at);
            check("dout", bus.dout, e.dout);
            check("busy_at_done", bus.busy, 1'b0);
`ifdef USR_PREV_CAPTURE_EN
            check("prev_sb", bus.prev, e.prev);
`endif
         end
      end
   end

   task automatic run_load(input logic [W-1:0] d, input logic dr);
      logic [1:0] exp_sel;
      exp_sel   = dr ? 2'b10 : 2'b01;
      bus.start = 1'b1;
      bus.dir   = dr;
      bus.din   = d;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < W; i++) begin
         check("shift_sel", bus.sel, exp_sel);
         check("shift_rdin", bus.rdin, dr ? 1'b0 : d[i]);
         check("shift_ldin", bus.ldin, dr ? d[W-1-i] : 1'b0);
         check("shift_busy", bus.busy, 1'b1);
         @(negedge clk);
      end
      repeat (2) begin
         check("cap_sel", bus.sel, 2'b11);
         check("cap_serial", {bus.rdin, bus.ldin}, 2'b00);
         @(negedge clk);
      end
      check("samp_sel", bus.sel, 2'b00);
      check("samp_done", bus.done, 1'b0);
      @(negedge clk);
      check("done_pulse", bus.done, 1'b1);
      check("done_sel", bus.sel, 2'b00);
      @(negedge clk);
      check("done_drop", bus.done, 1'b0);
   endtask

   int n0;
   int seen;
   int e1;
   int e2;

   initial begin
      bus.start = 1'b0;
      bus.dir   = 1'b0;
      bus.din   = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_dout", bus.dout, 4'b0000);
      check("rst_sel", bus.sel, 2'b00);
      check("rst_serial", {bus.rdin, bus.ldin}, 2'b00);
`ifdef USR_PREV_CAPTURE_EN
      check("rst_prev", bus.prev, 4'b0000);
`endif
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("idle_state", {bus.busy, bus.done, bus.sel, bus.rdin, bus.ldin, bus.dout}, '0);
      end

      run_load(4'b1011, 1'b0);
      run_load(4'b0110, 1'b1);
`ifdef USR_PREV_CAPTURE_EN
      check("prev_after_0110", bus.prev, 4'b1011);
`endif
      run_load(4'b0000, 1'b0);
`ifdef USR_PREV_CAPTURE_EN
      check("prev_after_0000", bus.prev, 4'b0110);
`endif

      // start held high: only the done-cycle request is taken.
      n0 = dones; seen = 0; e1 = 0; e2 = 0;
      bus.start = 1'b1; bus.dir = 1'b0; bus.din = 4'b1100;
      @(negedge clk);
      bus.din = 4'b0011;
      for (int i = 0; i < 40 && seen < 2; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen++;
            if (seen == 1) e1 = edge_n;
            else begin e2 = edge_n; bus.start = 1'b0; end
         end
      end
      bus.start = 1'b0;
      check("b2b_dones", seen, 2);
      check("b2b_gap", e2 - e1, 8);
      repeat (12) @(negedge clk);
      check("b2b_no_extra", dones - n0, 2);
      check("b2b_idle", bus.busy, 1'b0);

      // Abort during the third shift cycle.
      n0 = dones;
      bus.start = 1'b1; bus.dir = 1'b0; bus.din = 4'b0101;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_sel", bus.sel, 2'b00);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      repeat (10) @(negedge clk);
      check("abort_no_done", dones - n0, 0);
      run_load(4'b1001, 1'b0);
      check("after_abort_dout", bus.dout, 4'b1001);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
